pad_in_filter: RTL and testbench

Per-pin input conditioner between the chip pad inputs (`*_i` pad nets of `ppu0_top`) and the `io_in` inputs of the `iomux` instances. Each pin gets:
- a 2-flop synchronizer;
- a programmable glitch filter, implemented as a stability counter;
- a rise/fall edge detector;
- a sticky interrupt-pending bit.

Downstream logic (`gpio_in`, `scl_pad_i`, `sda_pad_i`, `spi_master_sdi0_i`) sees clean, `clk`-synchronous levels, and the core gets a pad-level wake/edge interrupt line.

---
 rtl/pad_filt_pkg.sv | 29 ++
 rtl/pad_in_filter_if.sv | 51 +++++
 rtl/pad_filt_chan.sv | 87 ++++++++
 rtl/pad_in_filter.sv | 56 +++++
 tb/tb_pad_in_filter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/pad_filt_pkg.sv
// Shared types and defaults for the pad input conditioner.
package pad_filt_pkg;

  // Per-pin interrupt edge selection, two bits per pin on the bus.
  typedef enum logic [1:0] {
    IRQ_RISE = 2'b00,
    IRQ_FALL = 2'b01,
    IRQ_BOTH = 2'b10,
    IRQ_NONE = 2'b11
  } irq_type_e;

  localparam int unsigned DefNpins = 8;
  localparam int unsigned DefCntW  = 8;

  // True when a filtered edge matches the selected interrupt type.
  function automatic logic irq_hit(irq_type_e t, logic rise, logic fall);
    logic hit;
    hit = 1'b0;
    unique case (t)
      IRQ_RISE: hit = rise;
      IRQ_FALL: hit = fall;
      IRQ_BOTH: hit = rise | fall;
      IRQ_NONE: hit = 1'b0;
      default:  hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/pad_in_filter_if.sv
// Bundle of the pad-conditioner configuration, raw pad inputs and filtered results.
// master: the side that drives pads/config and consumes results; slave: the filter.
interface pad_in_filter_if
  import pad_filt_pkg::*;
#(
  parameter int unsigned NPINS = DefNpins,
  parameter int unsigned CNT_W = DefCntW
);

  logic [NPINS-1:0]   pin_i;
  logic [NPINS-1:0]   filt_en_i;
  logic [CNT_W-1:0]   filt_len_i;
  logic [NPINS-1:0]   irq_en_i;
  logic [2*NPINS-1:0] irq_type_i;
  logic [NPINS-1:0]   irq_clr_i;

  logic [NPINS-1:0]   pin_o;
  logic [NPINS-1:0]   rise_o;
  logic [NPINS-1:0]   fall_o;
  logic [NPINS-1:0]   irq_pend_o;
  logic               irq_o;

  modport master (
    output pin_i,
    output filt_en_i,
    output filt_len_i,
    output irq_en_i,
    output irq_type_i,
    output irq_clr_i,
    input  pin_o,
    input  rise_o,
    input  fall_o,
    input  irq_pend_o,
    input  irq_o
  );

  modport slave (
    input  pin_i,
    input  filt_en_i,
    input  filt_len_i,
    input  irq_en_i,
    input  irq_type_i,
    input  irq_clr_i,
    output pin_o,
    output rise_o,
    output fall_o,
    output irq_pend_o,
    output irq_o
  );

endinterface

// File: rtl/pad_filt_chan.sv
// One pad channel: 2-flop synchronizer, stability-counter glitch filter,
// edge pulses and a sticky interrupt-pending bit.
module pad_filt_chan
  import pad_filt_pkg::*;
#(
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pin_i,
  input  logic             filt_en_i,
  input  logic [CNT_W-1:0] filt_len_i,
  input  logic             irq_en_i,
  input  irq_type_e        irq_type_i,
  input  logic             irq_clr_i,
  output logic             pin_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             irq_pend_o,
  output logic             pend_d_o
);

  logic             s1_q, s2_q;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             pend_q, pend_d;
  logic             update;
  logic             ev;

  // Synchronize the asynchronous pad into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= pin_i;
      s2_q <= s1_q;
    end
  end

  // Filter, edge and pending next-state. The >= compare lets a shortened
  // filter length take effect immediately instead of waiting for a wrap.
  always_comb begin
    update = 1'b0;
    filt_d = filt_q;
    cnt_d  = '0;
    if (s2_q != filt_q) begin
      if (!filt_en_i || (cnt_q >= filt_len_i)) begin
        update = 1'b1;
        filt_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = update & s2_q;
    fall_d = update & ~s2_q;
    ev     = irq_en_i & irq_hit(irq_type_i, rise_d, fall_d);
    // A new event wins over a coincident clear.
    pend_d = ev | (pend_q & ~irq_clr_i);
  end

  // Filter, edge and pending state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      pend_q <= pend_d;
    end
  end

  assign pin_o      = filt_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign irq_pend_o = pend_q;
  assign pend_d_o   = pend_d;

endmodule

// File: rtl/pad_in_filter.sv
// Per-pin pad input conditioner: NPINS independent channels plus the
// combined pad interrupt line.
module pad_in_filter
  import pad_filt_pkg::*;
#(
  parameter int unsigned NPINS = DefNpins,
  parameter int unsigned CNT_W = DefCntW
) (
  input logic            clk,
  input logic            rst_n,
  pad_in_filter_if.slave bus
);

  logic [NPINS-1:0] pin_vec;
  logic [NPINS-1:0] rise_vec;
  logic [NPINS-1:0] fall_vec;
  logic [NPINS-1:0] pend_vec;
  logic [NPINS-1:0] pend_d_vec;
  logic             irq_q;

  for (genvar i = 0; i < NPINS; i++) begin : g_chan
    pad_filt_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .pin_i      (bus.pin_i[i]),
      .filt_en_i  (bus.filt_en_i[i]),
      .filt_len_i (bus.filt_len_i),
      .irq_en_i   (bus.irq_en_i[i]),
      .irq_type_i (irq_type_e'(bus.irq_type_i[2*i +: 2])),
      .irq_clr_i  (bus.irq_clr_i[i]),
      .pin_o      (pin_vec[i]),
      .rise_o     (rise_vec[i]),
      .fall_o     (fall_vec[i]),
      .irq_pend_o (pend_vec[i]),
      .pend_d_o   (pend_d_vec[i])
    );
  end

  // Register the OR of next-state pending bits so irq_o lines up with irq_pend_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |pend_d_vec;
    end
  end

  assign bus.pin_o      = pin_vec;
  assign bus.rise_o     = rise_vec;
  assign bus.fall_o     = fall_vec;
  assign bus.irq_pend_o = pend_vec;
  assign bus.irq_o      = irq_q;

endmodule

// File: tb/tb_pad_in_filter.sv
// Directed plus randomized checks of pad_in_filter against a cycle-level
// reference model built from the behavioural rules of the conditioner.
module tb_pad_in_filter;
  import pad_filt_pkg::*;

  localparam int unsigned NP = 8;
  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pad_in_filter_if #(.NPINS(NP), .CNT_W(CW)) bus ();

  pad_in_filter #(.NPINS(NP), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  logic [NP-1:0] m_s1, m_s2, m_filt, m_rise, m_fall, m_pend;
  logic          m_irq;
  int            m_run[NP];   // consecutive edges the synced pad disagreed with the filtered level

  function automatic void model_zero();
    m_s1 = '0; m_s2 = '0; m_filt = '0; m_rise = '0; m_fall = '0; m_pend = '0;
    m_irq = 1'b0;
    for (int p = 0; p < NP; p++) m_run[p] = 0;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void model_step();
    logic [NP-1:0] nf, nr, nfl, np;
    nf = m_filt; nr = '0; nfl = '0; np = '0;
    for (int p = 0; p < NP; p++) begin
      bit differs, need_wait, chg, want_r, want_f, ev;
      logic [1:0] t;
      differs   = (m_s2[p] != m_filt[p]);
      need_wait = bus.filt_en_i[p] && (m_run[p] < int'(bus.filt_len_i));
      chg       = differs && !need_wait;
      if (chg) nf[p] = m_s2[p];
      m_run[p]  = (differs && !chg) ? m_run[p] + 1 : 0;
      nr[p]     = chg && m_s2[p];
      nfl[p]    = chg && !m_s2[p];
      t         = bus.irq_type_i[2*p +: 2];
      want_r    = (t == 2'b00) || (t == 2'b10);
      want_f    = (t == 2'b01) || (t == 2'b10);
      ev        = bus.irq_en_i[p] && ((nr[p] && want_r) || (nfl[p] && want_f));
      np[p]     = ev || (m_pend[p] && !bus.irq_clr_i[p]);
    end
    m_filt = nf; m_rise = nr; m_fall = nfl; m_pend = np;
    m_irq  = |np;
    m_s2   = m_s1;
    m_s1   = bus.pin_i;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("pin_o", 32'(bus.pin_o), 32'(m_filt));
    chk("rise_o", 32'(bus.rise_o), 32'(m_rise));
    chk("fall_o", 32'(bus.fall_o), 32'(m_fall));
    chk("irq_pend_o", 32'(bus.irq_pend_o), 32'(m_pend));
    chk("irq_o", 32'(bus.irq_o), 32'(m_irq));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset taken between edges; released one tick after an edge.
  task automatic async_reset();
    rst_n = 1'b0;
    model_zero();
    #1;
    chk_all();
    chk("rst pin_o", 32'(bus.pin_o), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk_all();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NP-1:0] hi_pins;
    rst_n          = 1'b0;
    bus.pin_i      = '0;
    bus.filt_en_i  = '0;
    bus.filt_len_i = '0;
    bus.irq_en_i   = '0;
    bus.irq_type_i = {NP{IRQ_NONE}};
    bus.irq_clr_i  = '0;
    model_zero();
    #1;
    chk_all();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Bypass: pin 0 rises, visible at edge 2 with a one-cycle rise pulse.
    bus.pin_i[0] = 1'b1;
    steps(2);
    chk("A pin_o0 early", 32'(bus.pin_o[0]), 32'd0);
    step();
    chk("A pin_o0", 32'(bus.pin_o[0]), 32'd1);
    chk("A rise0", 32'(bus.rise_o[0]), 32'd1);
    step();
    chk("A rise0 width", 32'(bus.rise_o[0]), 32'd0);

    // N=5: a 5-cycle pulse is swallowed, a long one passes at edge 7.
    bus.filt_en_i  = '1;
    bus.filt_len_i = 8'd5;
    bus.pin_i[1]   = 1'b1;
    steps(5);
    bus.pin_i[1]   = 1'b0;
    steps(8);
    chk("B glitch pin_o1", 32'(bus.pin_o[1]), 32'd0);
    bus.pin_i[1]   = 1'b1;
    steps(7);
    chk("B pin_o1 before", 32'(bus.pin_o[1]), 32'd0);
    step();
    chk("B pin_o1", 32'(bus.pin_o[1]), 32'd1);
    chk("B rise1", 32'(bus.rise_o[1]), 32'd1);

    // N=200 then shortened to 3 while the count sits at 50.
    bus.filt_len_i = 8'd200;
    bus.pin_i[4]   = 1'b1;
    steps(52);
    chk("C pin_o4 mid", 32'(bus.pin_o[4]), 32'd0);
    bus.filt_len_i = 8'd3;
    step();
    chk("C pin_o4", 32'(bus.pin_o[4]), 32'd1);

    // Pin 2, both edges: clear coincident with the fall event loses.
    bus.filt_len_i       = 8'd0;
    bus.irq_en_i[2]      = 1'b1;
    bus.irq_type_i[5:4]  = IRQ_BOTH;
    bus.pin_i[2]         = 1'b1;
    steps(3);
    chk("D pend2 rise", 32'(bus.irq_pend_o[2]), 32'd1);
    chk("D irq_o", 32'(bus.irq_o), 32'd1);
    bus.pin_i[2]         = 1'b0;
    steps(2);
    bus.irq_clr_i[2]     = 1'b1;
    step();
    bus.irq_clr_i[2]     = 1'b0;
    chk("D fall2", 32'(bus.fall_o[2]), 32'd1);
    chk("D pend2 set wins", 32'(bus.irq_pend_o[2]), 32'd1);
    bus.irq_clr_i[2]     = 1'b1;
    step();
    bus.irq_clr_i[2]     = 1'b0;
    chk("D pend2 cleared", 32'(bus.irq_pend_o[2]), 32'd0);
    chk("D irq_o cleared", 32'(bus.irq_o), 32'd0);

    // Pin 3 with type NONE, then with the enable off: pulses but no interrupt.
    bus.irq_en_i[3]     = 1'b1;
    bus.irq_type_i[7:6] = IRQ_NONE;
    for (int k = 0; k < 12; k++) begin
      if (k == 6) begin
        bus.irq_en_i[3]     = 1'b0;
        bus.irq_type_i[7:6] = IRQ_BOTH;
      end
      bus.pin_i[3] = ~bus.pin_i[3];
      steps(3);
      chk("E edge3", 32'(bus.rise_o[3] | bus.fall_o[3]), 32'd1);
      step();
      chk("E irq_o", 32'(bus.irq_o), 32'd0);
    end

    // Reset mid-count with pads high; release and watch the N+2 latency.
    bus.filt_len_i = 8'd10;
    bus.pin_i[5]   = 1'b1;
    steps(5);
    async_reset();
    hi_pins = bus.pin_i;
    steps(12);
    chk("F pin_o before", 32'(bus.pin_o), 32'h0);
    step();
    chk("F pin_o", 32'(bus.pin_o), 32'(hi_pins));
    chk("F rise", 32'(bus.rise_o), 32'(hi_pins));

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0) bus.filt_len_i = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 31) == 0) begin
        bus.filt_en_i  = NP'($urandom);
        bus.irq_en_i   = NP'($urandom);
        bus.irq_type_i = (2*NP)'($urandom);
      end
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 4) == 0) bus.pin_i[p] = ~bus.pin_i[p];
        bus.irq_clr_i[p] = ($urandom_range(0, 7) == 0);
      end
      if (n == 300) async_reset();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
